period_meter: RTL and testbench

//   Measures the period of an external square wave (sig_in) in sys_clk cycles.

---
 rtl/meas_pkg.sv | 32 +++
 rtl/sync_rise_det.sv | 27 ++
 rtl/period_meter.sv | 100 ++++++++++
 tb/tb_period_meter.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/meas_pkg.sv
// Shared types and helpers for the period meter: FSM state encoding and the
// period-to-LED bar-graph mapping.
package meas_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    MEASURE = 1'b1
  } meas_state_e;

  // Band comparisons are done at this width; WIDTH up to 32 bits fits.
  localparam int unsigned BAND_W = 32;

  // Active-high bar: more lit segments for longer periods.
  function automatic logic [2:0] led_band(
    input logic [BAND_W-1:0] p,
    input logic [BAND_W-1:0] th0,
    input logic [BAND_W-1:0] th1,
    input logic [BAND_W-1:0] th2
  );
    logic [2:0] bar;
    if (p < th0)      bar = 3'b000;
    else if (p < th1) bar = 3'b001;
    else if (p < th2) bar = 3'b011;
    else              bar = 3'b111;
    return bar;
  endfunction

  function automatic logic [2:0] led_pins(input logic [2:0] lit, input logic active_low);
    return active_low ? ~lit : lit;
  endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchroniser for an asynchronous input followed by a rising-edge
// detector; rise is a combinational one-cycle pulse off the synchronised level.
module sync_rise_det (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic d_async,
  output logic rise
);

  logic s1, s2, s2_d;

  // Reset to 1 so a level already high at reset release never looks like an edge.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      s1   <= 1'b1;
      s2   <= 1'b1;
      s2_d <= 1'b1;
    end else begin
      s1   <= d_async;
      s2   <= s1;
      s2_d <= s2;
    end
  end

  assign rise = s2 & ~s2_d;

endmodule

// File: rtl/period_meter.sv
// Times the rising-to-rising distance of sig_in in sys_clk cycles, flags a
// timeout when the wave stops, and shows the period band on three LEDs.
module period_meter
  import meas_pkg::*;
#(
  parameter int unsigned      WIDTH          = 24,
  parameter logic [WIDTH-1:0] TIMEOUT_CYCLES = 24'd1000000,
  parameter logic [WIDTH-1:0] TH0            = 24'd100,
  parameter logic [WIDTH-1:0] TH1            = 24'd1000,
  parameter logic [WIDTH-1:0] TH2            = 24'd10000,
  parameter bit               LED_ACTIVE_LOW = 1'b1
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic             period_valid,
  output logic             timeout,
  output logic [2:0]       led,
  output meas_state_e      state_dbg
);

  // period_valid is a one-cycle strobe with no ready/backpressure: a consumer
  // must capture period in the cycle period_valid is high, or it misses it.

  localparam logic [2:0] LED_UNLIT = LED_ACTIVE_LOW ? 3'b111 : 3'b000;

  logic             rise;
  meas_state_e      state, state_d;
  logic [WIDTH-1:0] cnt, cnt_d, cnt_inc;
  logic [WIDTH-1:0] period_d;
  logic             valid_d, timeout_d;
  logic [2:0]       led_d;

  sync_rise_det u_sync (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .d_async   (sig_in),
    .rise      (rise)
  );

  assign cnt_inc   = cnt + WIDTH'(1);
  assign state_dbg = state;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state        <= IDLE;
      cnt          <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
      led          <= LED_UNLIT;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      period       <= period_d;
      period_valid <= valid_d;
      timeout      <= timeout_d;
      led          <= led_d;
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    period_d  = period;
    valid_d   = 1'b0;
    timeout_d = timeout;
    led_d     = led;
    case (state)
      IDLE: begin
        // No earlier edge to measure from, so the first rise only arms the counter.
        cnt_d = '0;
        if (rise) state_d = MEASURE;
      end
      MEASURE: begin
        if (rise) begin
          period_d  = cnt_inc;
          valid_d   = 1'b1;
          timeout_d = 1'b0;
          cnt_d     = '0;
          led_d     = led_pins(led_band(BAND_W'(cnt_inc), BAND_W'(TH0),
                                        BAND_W'(TH1), BAND_W'(TH2)), LED_ACTIVE_LOW);
        end else if (cnt_inc == TIMEOUT_CYCLES) begin
          timeout_d = 1'b1;
          cnt_d     = '0;
          state_d   = IDLE;
          led_d     = LED_UNLIT;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_period_meter.sv
// Directed bench for period_meter: reset behaviour, measured periods, LED
// bands and thresholds, timeout entry/exit and reset mid-measurement.
module tb_period_meter;
  import meas_pkg::*;

  localparam int unsigned W   = 24;
  localparam int unsigned TMO = 20100;

  logic          sys_clk = 1'b0;
  logic          sys_rst_n;
  logic          sig_in;
  logic [W-1:0]  period;
  logic          period_valid;
  logic          timeout;
  logic [2:0]    led;
  meas_state_e   state_dbg;

  int n_tests     = 0;
  int n_fail      = 0;
  int strobes     = 0;
  int exp_strobes = 0;

  period_meter #(
    .WIDTH          (W),
    .TIMEOUT_CYCLES (24'd20100),
    .TH0            (24'd100),
    .TH1            (24'd1000),
    .TH2            (24'd10000),
    .LED_ACTIVE_LOW (1'b1)
  ) dut (
    .sys_clk      (sys_clk),
    .sys_rst_n    (sys_rst_n),
    .sig_in       (sig_in),
    .period       (period),
    .period_valid (period_valid),
    .timeout      (timeout),
    .led          (led),
    .state_dbg    (state_dbg)
  );

  // Clock / reset block
  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) if (period_valid === 1'b1) strobes++;

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Called right after sig_in was raised `used` cycles ago; raises it again
  // exactly n cycles after that earlier rise, with roughly half-period phases.
  task automatic wave(input int n, input int used);
    tick(n / 2 - used);
    sig_in = 1'b0;
    tick(n - n / 2);
    sig_in = 1'b1;
  endtask

  // A rise set just after edge j is registered at edge j+3; consumes 4 cycles.
  task automatic check_strobe(input string tag, input int exp_period, input logic [2:0] exp_led);
    tick(2);
    check({tag, "_pre_valid"}, 32'(period_valid), 32'd0);
    tick(1);
    exp_strobes++;
    check({tag, "_valid"},   32'(period_valid), 32'd1);
    check({tag, "_period"},  32'(period), 32'(exp_period));
    check({tag, "_led"},     32'(led), 32'(exp_led));
    check({tag, "_timeout"}, 32'(timeout), 32'd0);
    tick(1);
    check({tag, "_post_valid"}, 32'(period_valid), 32'd0);
  endtask

  initial begin
    // 1: sig_in high through reset gives no edge; then two rises 40 apart
    sys_rst_n = 1'b0;
    sig_in    = 1'b1;
    tick(3);
    check("rst_period",  32'(period), 32'd0);
    check("rst_valid",   32'(period_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    check("rst_led",     32'(led), 32'b111);
    check("rst_state",   32'(state_dbg), 32'(IDLE));
    sys_rst_n = 1'b1;
    tick(50);
    check("hold_high_strobes", 32'(strobes), 32'(exp_strobes));
    check("hold_high_period",  32'(period), 32'd0);
    check("hold_high_led",     32'(led), 32'b111);
    check("hold_high_state",   32'(state_dbg), 32'(IDLE));
    sig_in = 1'b0;
    tick(20);
    sig_in = 1'b1;
    tick(4);
    check("first_rise_state",   32'(state_dbg), 32'(MEASURE));
    check("first_rise_strobes", 32'(strobes), 32'(exp_strobes));
    wave(40, 4);
    check_strobe("p40", 40, 3'b111);
    check("p40_strobes", 32'(strobes), 32'(exp_strobes));

    // 3: band mapping, including the TH0 boundary
    wave(50, 4);    check_strobe("p50",   50,   3'b111);
    wave(99, 4);    check_strobe("p99",   99,   3'b111);
    wave(100, 4);   check_strobe("p100",  100,  3'b110);
    wave(500, 4);   check_strobe("p500",  500,  3'b110);
    wave(5000, 4);  check_strobe("p5000", 5000, 3'b100);

    // 2: 10001 high / 10001 low square wave
    wave(20002, 4); check_strobe("p20002", 20002, 3'b000);
    check("p20002_strobes", 32'(strobes), 32'(exp_strobes));

    // 4: stop toggling; timeout exactly TMO cycles after the detect edge
    tick(TMO - 2);
    check("tmo_pre",        32'(timeout), 32'd0);
    tick(1);
    check("tmo_set",        32'(timeout), 32'd1);
    check("tmo_led",        32'(led), 32'b111);
    check("tmo_period",     32'(period), 32'd20002);
    check("tmo_state",      32'(state_dbg), 32'(IDLE));
    check("tmo_strobes",    32'(strobes), 32'(exp_strobes));
    sig_in = 1'b0;
    tick(10);
    sig_in = 1'b1;
    tick(4);
    check("tmo_rise1_timeout", 32'(timeout), 32'd1);
    check("tmo_rise1_state",   32'(state_dbg), 32'(MEASURE));
    check("tmo_rise1_strobes", 32'(strobes), 32'(exp_strobes));
    wave(60, 4);    check_strobe("p60_after_tmo", 60, 3'b111);

    // 5: rise coinciding with the timeout boundary wins
    wave(TMO, 4);   check_strobe("p_tmo_exact", int'(TMO), 3'b000);
    check("tmo_exact_strobes", 32'(strobes), 32'(exp_strobes));

    // 6: one-cycle reset mid-measurement
    sig_in = 1'b0;
    tick(10);
    sys_rst_n = 1'b0;
    tick(1);
    sys_rst_n = 1'b1;
    check("rst2_period",  32'(period), 32'd0);
    check("rst2_valid",   32'(period_valid), 32'd0);
    check("rst2_timeout", 32'(timeout), 32'd0);
    check("rst2_led",     32'(led), 32'b111);
    check("rst2_state",   32'(state_dbg), 32'(IDLE));
    tick(3);
    sig_in = 1'b1;
    tick(5);
    check("rst2_rise1_strobes", 32'(strobes), 32'(exp_strobes));
    check("rst2_rise1_period",  32'(period), 32'd0);
    check("rst2_rise1_state",   32'(state_dbg), 32'(MEASURE));
    wave(30, 5);    check_strobe("p30_after_rst", 30, 3'b111);
    tick(2);
    check("final_strobes", 32'(strobes), 32'(exp_strobes));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
